// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL opcode constants and A-to-D expected response mapping.
package tlul_pkg;
  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic       legal;
    logic [2:0] d_op;
  } exp_t;

  function automatic exp_t tl_expected(input logic [2:0] a_op);
    exp_t e;
    e.legal = (a_op == A_GET) || (a_op == A_PUT_FULL) || (a_op == A_PUT_PARTIAL);
    e.d_op  = (a_op == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    return e;
  endfunction
endpackage

// File: rtl/tlul_mon_fifo.sv
// tlul_mon_fifo: per-channel in-order tracker of expected responses.
// Callers never push when full without a pop, nor pop when empty.
module tlul_mon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
endmodule

// File: rtl/tlul_txn_monitor.sv
// tlul_txn_monitor: per-channel TL-UL A/D protocol checker with statistics.
// Define TLUL_MON_LATENCY_EN to stamp requests and track max latency.
module tlul_txn_monitor
  import tlul_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 1024,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CH-1:0]                        a_valid,
  input  logic [N_CH-1:0]                        a_ready,
  input  logic [N_CH*OPCODE_WIDTH-1:0]           a_opcode,
  input  logic [N_CH-1:0]                        d_valid,
  input  logic [N_CH-1:0]                        d_ready,
  input  logic [N_CH*OPCODE_WIDTH-1:0]           d_opcode,
  input  logic                                   clear,
  output logic [N_CH-1:0]                        err_overflow,
  output logic [N_CH-1:0]                        err_underflow,
  output logic [N_CH-1:0]                        err_opcode,
  output logic [N_CH-1:0]                        err_timeout,
  output logic                                   any_err,
  output logic [N_CH*($clog2(DEPTH)+1)-1:0]      outstanding,
  output logic [N_CH*32-1:0]                     txn_count,
  output logic [N_CH*16-1:0]                     lat_max
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = OPCODE_WIDTH;
`ifdef TLUL_MON_LATENCY_EN
  localparam int FW = OW + 16;
  logic [15:0] r_now;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_now <= '0;
    else r_now <= r_now + 16'd1;
  end
`else
  localparam int FW = OW;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic          w_a_fire, w_d_fire, w_push, w_pop, w_full, w_empty, w_legal;
    logic          w_ev_ovf, w_ev_udf, w_ev_opc, w_ev_to;
    logic [OW-1:0] w_a_op, w_d_op;
    logic [FW-1:0] w_din, w_dout;
    exp_t          w_e;
    logic          r_ovf, r_udf, r_opc, r_to_flag;
    logic [31:0]   r_txn;

    assign w_a_op   = a_opcode[c*OW +: OW];
    assign w_d_op   = d_opcode[c*OW +: OW];
    assign w_a_fire = a_valid[c] && a_ready[c];
    assign w_d_fire = d_valid[c] && d_ready[c];
    assign w_e      = tl_expected(w_a_op[2:0]);
    assign w_legal  = w_e.legal && (w_a_op == OW'(w_a_op[2:0]));
    assign w_pop    = w_d_fire && !w_empty;
    // A full tracker still accepts a push when the head leaves in the same cycle
    assign w_push   = w_a_fire && w_legal && (!w_full || w_pop);
    assign w_ev_ovf = w_a_fire && w_legal && w_full && !w_d_fire;
    assign w_ev_udf = w_d_fire && w_empty;
    assign w_ev_opc = (w_a_fire && !w_legal) || (w_pop && (w_d_op != w_dout[OW-1:0]));
`ifdef TLUL_MON_LATENCY_EN
    logic [15:0] w_lat, r_lat;
    assign w_din = {r_now, OW'(w_e.d_op)};
    assign w_lat = r_now - w_dout[FW-1 -: 16];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_lat <= '0;
      else r_lat <= clear ? '0 : (w_pop && w_lat > r_lat) ? w_lat : r_lat;
    end
    assign lat_max[c*16 +: 16] = r_lat;
`else
    assign w_din = OW'(w_e.d_op);
    assign lat_max[c*16 +: 16] = '0;
`endif

    tlul_mon_fifo #(.DEPTH(DEPTH), .W(FW), .CW(CW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_din),
      .o_data  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (outstanding[c*CW +: CW])
    );

    if (TIMEOUT > 0) begin : g_to
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] r_to;
      logic          w_inc;
      assign w_inc   = !w_empty && !w_d_fire && (r_to != TW'(TIMEOUT));
      // Flag fires only on the edge the counter reaches TIMEOUT, so a later clear sticks
      assign w_ev_to = w_inc && (r_to == TW'(TIMEOUT - 1));
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_to <= '0;
        else r_to <= (w_empty || w_d_fire) ? '0 : w_inc ? r_to + 1'b1 : r_to;
      end
    end else begin : g_no_to
      assign w_ev_to = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
        r_opc     <= 1'b0;
        r_to_flag <= 1'b0;
        r_txn     <= '0;
      end else begin
        r_ovf     <= (r_ovf && !clear) || w_ev_ovf;
        r_udf     <= (r_udf && !clear) || w_ev_udf;
        r_opc     <= (r_opc && !clear) || w_ev_opc;
        r_to_flag <= (r_to_flag && !clear) || w_ev_to;
        r_txn     <= clear ? '0 : r_txn + 32'(w_pop);
      end
    end

    assign err_overflow[c]       = r_ovf;
    assign err_underflow[c]      = r_udf;
    assign err_opcode[c]         = r_opc;
    assign err_timeout[c]        = r_to_flag;
    assign txn_count[c*32 +: 32] = r_txn;
  end

  assign any_err = |{err_overflow, err_underflow, err_opcode, err_timeout};
endmodule

// File: tb/tb_tlul_txn_monitor.sv
// tb_tlul_txn_monitor: directed checks of tlul_txn_monitor (N_CH=3, DEPTH=4, TIMEOUT=16).
module tb_tlul_txn_monitor;
  localparam int N = 3;
  localparam int OW = 3;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    a_valid = '0, a_ready = '1, d_valid = '0, d_ready = '1;
  logic [N*OW-1:0] a_opcode = '0, d_opcode = '0;
  logic            clear = 1'b0;
  logic [N-1:0]    err_overflow, err_underflow, err_opcode, err_timeout;
  logic            any_err;
  logic [N*CW-1:0] outstanding;
  logic [N*32-1:0] txn_count;
  logic [N*16-1:0] lat_max;
  int total = 0;
  int bad = 0;

  tlul_txn_monitor #(.N_CH(N), .DEPTH(4), .TIMEOUT(16), .OPCODE_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .clear(clear),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_opcode(err_opcode), .err_timeout(err_timeout), .any_err(any_err),
    .outstanding(outstanding), .txn_count(txn_count), .lat_max(lat_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = '0;
    d_valid = '0;
    a_ready = '1;
    clear = 1'b0;
  endtask

  task automatic a_req(input int ch, input logic [2:0] op);
    a_valid[ch] = 1'b1;
    a_opcode[ch*OW +: OW] = op;
  endtask

  task automatic d_rsp(input int ch, input logic [2:0] op);
    d_valid[ch] = 1'b1;
    d_opcode[ch*OW +: OW] = op;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [2:0] occ(input int c);
    return outstanding[c*CW +: CW];
  endfunction

  function automatic logic [31:0] tc(input int c);
    return txn_count[c*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    reset = 1'b1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_any_err", 64'(any_err), 64'd0);
    chk("rst_lat_max", 64'(lat_max), 64'd0);
    for (int c = 0; c < N; c++) chk("rst_txn", 64'(tc(c)), 64'd0);

    // A valid without ready is not a fire
    a_req(0, 3'd4);
    a_ready[0] = 1'b0;
    tick();
    idle();
    chk("no_fire_occ", 64'(occ(0)), 64'd0);

    // ch0 Get answered 5 cycles later
    a_req(0, 3'd4);
    tick();
    idle();
    chk("get_occ", 64'(occ(0)), 64'd1);
    repeat (4) tick();
    d_rsp(0, 3'd1);
    tick();
    idle();
    chk("get_txn", 64'(tc(0)), 64'd1);
    chk("get_occ_after", 64'(occ(0)), 64'd0);
    chk("get_no_err", 64'(any_err), 64'd0);
`ifdef TLUL_MON_LATENCY_EN
    chk("get_lat", 64'(lat_max[15:0]), 64'd5);
`else
    chk("get_lat", 64'(lat_max[15:0]), 64'd0);
`endif

    // ch1 PutFull answered with AccessAckData
    a_req(1, 3'd0);
    tick();
    idle();
    d_rsp(1, 3'd1);
    tick();
    idle();
    chk("pf_opc", 64'(err_opcode), 64'b010);
    chk("pf_any", 64'(any_err), 64'd1);
    chk("pf_ovf", 64'(err_overflow), 64'd0);
    chk("pf_udf", 64'(err_underflow), 64'd0);
    chk("pf_txn", 64'(tc(1)), 64'd1);
    do_clear();
    chk("clr_any", 64'(any_err), 64'd0);
    chk("clr_txn0", 64'(tc(0)), 64'd0);
    chk("clr_lat", 64'(lat_max), 64'd0);

    // Unsupported A opcode pushes nothing
    a_req(0, 3'd2);
    tick();
    idle();
    chk("bad_a_opc", 64'(err_opcode), 64'b001);
    chk("bad_a_occ", 64'(occ(0)), 64'd0);
    do_clear();

    // FIFO ordering: Get then PutFull answered in order
    a_req(0, 3'd4);
    tick();
    a_req(0, 3'd0);
    tick();
    idle();
    d_rsp(0, 3'd1);
    tick();
    d_rsp(0, 3'd0);
    tick();
    idle();
    chk("order_ok_opc", 64'(err_opcode), 64'd0);
    chk("order_ok_txn", 64'(tc(0)), 64'd2);
    chk("order_ok_occ", 64'(occ(0)), 64'd0);
    a_req(0, 3'd0);
    tick();
    a_req(0, 3'd4);
    tick();
    idle();
    d_rsp(0, 3'd1);
    tick();
    idle();
    chk("order_bad_opc", 64'(err_opcode), 64'b001);
    d_rsp(0, 3'd1);
    tick();
    idle();
    chk("order_drain_occ", 64'(occ(0)), 64'd0);
    do_clear();

    // ch2 overflow
    a_req(2, 3'd4);
    repeat (4) tick();
    chk("fill_occ", 64'(occ(2)), 64'd4);
    chk("fill_ovf", 64'(err_overflow), 64'd0);
    tick();
    idle();
    chk("ovf_flag", 64'(err_overflow), 64'b100);
    chk("ovf_occ", 64'(occ(2)), 64'd4);
    do_clear();
    chk("ovf_clr", 64'(err_overflow), 64'd0);
    a_req(2, 3'd4);
    d_rsp(2, 3'd1);
    tick();
    idle();
    chk("full_ad_ovf", 64'(err_overflow), 64'd0);
    chk("full_ad_occ", 64'(occ(2)), 64'd4);
    chk("full_ad_txn", 64'(tc(2)), 64'd1);
    d_rsp(2, 3'd1);
    repeat (4) tick();
    idle();
    chk("drain_occ", 64'(occ(2)), 64'd0);
    chk("drain_opc", 64'(err_opcode), 64'd0);

    // Underflow, alone and with a same-cycle A fire
    d_rsp(1, 3'd0);
    tick();
    idle();
    chk("udf_flag", 64'(err_underflow), 64'b010);
    chk("udf_occ", 64'(occ(1)), 64'd0);
    do_clear();
    a_req(1, 3'd4);
    d_rsp(1, 3'd1);
    tick();
    idle();
    chk("udf_ad_flag", 64'(err_underflow), 64'b010);
    chk("udf_ad_occ", 64'(occ(1)), 64'd1);
    clear = 1'b1;
    d_rsp(0, 3'd0);
    tick();
    idle();
    chk("err_beats_clr", 64'(err_underflow), 64'b001);
    d_rsp(1, 3'd1);
    tick();
    idle();
    chk("udf_pop_occ", 64'(occ(1)), 64'd0);
    chk("udf_pop_opc", 64'(err_opcode), 64'd0);
    chk("udf_pop_txn", 64'(tc(1)), 64'd1);
    do_clear();

    // Timeout at exactly 16 cycles after the A fire
    a_req(0, 3'd4);
    tick();
    idle();
    repeat (15) tick();
    chk("to_before", 64'(err_timeout), 64'd0);
    tick();
    chk("to_flag", 64'(err_timeout), 64'b001);
    do_clear();
    chk("to_clr", 64'(err_timeout), 64'd0);
    chk("to_clr_occ", 64'(occ(0)), 64'd1);
    repeat (3) tick();
    chk("to_sat", 64'(err_timeout), 64'd0);

    // Asynchronous reset with 2 outstanding
    a_req(0, 3'd4);
    tick();
    idle();
    chk("pre_rst_occ", 64'(occ(0)), 64'd2);
    d_rsp(2, 3'd0);
    tick();
    idle();
    chk("pre_rst_udf", 64'(err_underflow), 64'b100);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_occ", 64'(outstanding), 64'd0);
    chk("arst_any", 64'(any_err), 64'd0);
    chk("arst_lat", 64'(lat_max), 64'd0);
    for (int c = 0; c < N; c++) chk("arst_txn", 64'(tc(c)), 64'd0);
    tick();
    reset = 1'b1;
    d_rsp(0, 3'd1);
    tick();
    idle();
    chk("post_rst_udf", 64'(err_underflow), 64'b001);
    chk("post_rst_occ", 64'(occ(0)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
